score_keeper: RTL

//  Point-tracking FSM for the pong datapath. Sits between ball/paddle collision logic (upstream) and the
//  7-segment score display (downstream, consumes Lscore/Rscore). Turns edge-miss pulses into per-player

---
 rtl/score_keeper.sv | 118 +++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// Pong point tracker: converts miss pulses into per-player scores, holds a timed
// serve pause after each point and flags the end of the game with its winner.
module score_keeper #(
    parameter int WIN_SCORE    = 7,
    parameter int PAUSE_CYCLES = 100_000_000,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic [2:0] Lscore,
    output logic [2:0] Rscore,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [2:0]       WIN        = 3'(WIN_SCORE);
    localparam logic [CNT_W-1:0] PAUSE_LAST = CNT_W'(PAUSE_CYCLES - 1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       l_nx, r_nx;
    logic             sd_nx, go_nx, win_nx;

    always_comb begin
        state_nx = state;
        cnt_nx   = '0;
        l_nx     = Lscore;
        r_nx     = Rscore;
        sd_nx    = serve_dir;
        go_nx    = game_over;
        win_nx   = winner;
        case (state)
            IDLE: begin
                l_nx = 3'd0;
                r_nx = 3'd0;
                if (start) state_nx = PLAY;
            end
            PLAY: begin
                // A simultaneous double miss is replayed without scoring.
                if (miss_left && miss_right) begin
                    state_nx = PAUSE;
                end else if (miss_right) begin
                    l_nx  = Lscore + 3'd1;
                    sd_nx = 1'b1;
                    if (l_nx == WIN) begin
                        state_nx = OVER;
                        go_nx    = 1'b1;
                        win_nx   = 1'b0;
                    end else begin
                        state_nx = PAUSE;
                    end
                end else if (miss_left) begin
                    r_nx  = Rscore + 3'd1;
                    sd_nx = 1'b0;
                    if (r_nx == WIN) begin
                        state_nx = OVER;
                        go_nx    = 1'b1;
                        win_nx   = 1'b1;
                    end else begin
                        state_nx = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (cnt == PAUSE_LAST) state_nx = PLAY;
                else                   cnt_nx   = cnt + 1'b1;
            end
            OVER: begin
                // serve_dir is left untouched so the loser serves first.
                if (start) begin
                    l_nx     = 3'd0;
                    r_nx     = 3'd0;
                    go_nx    = 1'b0;
                    state_nx = PAUSE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            Lscore     <= 3'd0;
            Rscore     <= 3'd0;
            ball_reset <= 1'b1;
            serve_dir  <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            Lscore     <= l_nx;
            Rscore     <= r_nx;
            ball_reset <= (state_nx != PLAY);
            serve_dir  <= sd_nx;
            game_over  <= go_nx;
            winner     <= win_nx;
        end
    end

    assign dbg_state = state;

endmodule
